// File: rtl/exception_controller.sv
// CP0 writer and PC-redirect controller: arbitrates interrupts, exceptions, eret and mtc0 from M.
// Optional macro EXC_HOLDOFF_EN adds an interrupt holdoff window after each eret redirect.
module exception_controller #(
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180
`ifdef EXC_HOLDOFF_EN
    ,
    parameter int unsigned HOLDOFF_CYCLES = 3
`endif
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  HWInt,
    input  logic [31:0] victim_pc,
    input  logic        victim_bd,
    input  logic        exc_valid,
    input  logic [4:0]  exc_code,
    input  logic        eret_req,
    input  logic        mtc0_valid,
    input  logic [4:0]  mtc0_addr,
    input  logic [31:0] mtc0_data,
    input  logic [31:0] SR_value,
    input  logic [31:0] Cause_value,
    input  logic [31:0] EPC_value,
    output logic [31:0] SR_input,
    output logic        SR_enable,
    output logic [31:0] Cause_input,
    output logic        Cause_enable,
    output logic [31:0] EPC_input,
    output logic        EPC_enable,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        busy
);

    localparam int unsigned SR_IE     = 0;
    localparam int unsigned SR_EXL    = 1;
    localparam int unsigned IM_LO     = 10;
    localparam int unsigned IM_HI     = 15;
    localparam int unsigned CAUSE_BD  = 31;
    localparam int unsigned EXC_LO    = 2;
    localparam int unsigned EXC_HI    = 6;
    localparam logic [4:0]  REG_SR    = 5'd12;
    localparam logic [4:0]  REG_EPC   = 5'd14;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_TRAP = 2'd1,
        ST_ERET = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        redirect_valid_d;
    logic [31:0] redirect_pc_d;
    logic        run;
    logic        int_take;
    logic        exc_take;
    logic        take;
    logic        eret_go;
    logic        holdoff_clear;
    logic [31:0] victim_epc;

`ifdef EXC_HOLDOFF_EN
    localparam int unsigned HOLD_W = (HOLDOFF_CYCLES < 2) ? 1 : $clog2(HOLDOFF_CYCLES + 1);

    logic [HOLD_W-1:0] holdoff_q;

    assign holdoff_clear = (holdoff_q == '0);

    // Loaded by an accepted eret; counts down only while back in RUN.
    always_ff @(posedge clk) begin
        if (!reset) begin
            holdoff_q <= '0;
        end else if (eret_go) begin
            holdoff_q <= HOLD_W'(HOLDOFF_CYCLES);
        end else if ((state_q == ST_RUN) && !holdoff_clear) begin
            holdoff_q <= holdoff_q - HOLD_W'(1);
        end
    end
`else
    assign holdoff_clear = 1'b1;
`endif

    // Reset low suppresses every request so all write enables stay low.
    assign run      = (state_q == ST_RUN) && reset;
    assign int_take = run && SR_value[SR_IE] && !SR_value[SR_EXL]
                      && (|(HWInt & SR_value[IM_HI:IM_LO])) && holdoff_clear;
    assign exc_take = run && exc_valid && !int_take;
    assign take     = int_take || exc_take;
    assign eret_go  = run && eret_req && !take;

    assign victim_epc = (victim_bd ? (victim_pc - 32'd4) : victim_pc) & 32'hFFFF_FFFC;
    assign busy       = (state_q != ST_RUN);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= ST_RUN;
            redirect_valid <= 1'b0;
            redirect_pc    <= 32'd0;
        end else begin
            state_q        <= state_d;
            redirect_valid <= redirect_valid_d;
            redirect_pc    <= redirect_pc_d;
        end
    end

    always_comb begin
        state_d          = ST_RUN;
        redirect_valid_d = 1'b0;
        redirect_pc_d    = redirect_pc;
        SR_enable        = 1'b0;
        SR_input         = SR_value;
        Cause_enable     = 1'b0;
        Cause_input      = Cause_value;
        EPC_enable       = 1'b0;
        EPC_input        = EPC_value;

        if (run) begin
            // IP mirrors the raw lines every RUN cycle; other Cause fields change only on a take.
            Cause_enable              = 1'b1;
            Cause_input[IM_HI:IM_LO]  = HWInt;

            if (take) begin
                SR_enable                  = 1'b1;
                SR_input[SR_EXL]           = 1'b1;
                EPC_enable                 = 1'b1;
                EPC_input                  = victim_epc;
                Cause_input[CAUSE_BD]      = victim_bd;
                Cause_input[EXC_HI:EXC_LO] = int_take ? 5'd0 : exc_code;
                state_d                    = ST_TRAP;
                redirect_valid_d           = 1'b1;
                redirect_pc_d              = HANDLER_PC;
            end else if (eret_req) begin
                SR_enable        = 1'b1;
                SR_input[SR_EXL] = 1'b0;
                state_d          = ST_ERET;
                redirect_valid_d = 1'b1;
                redirect_pc_d    = EPC_value;
            end else if (mtc0_valid) begin
                case (mtc0_addr)
                    REG_SR: begin
                        SR_enable = 1'b1;
                        SR_input  = mtc0_data;
                    end
                    REG_EPC: begin
                        EPC_enable = 1'b1;
                        EPC_input  = mtc0_data;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_exception_controller.sv
// Directed self-checking bench for exception_controller; follows EXC_HOLDOFF_EN like the DUT.
module tb_exception_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  HWInt;
    logic [31:0] victim_pc;
    logic        victim_bd;
    logic        exc_valid;
    logic [4:0]  exc_code;
    logic        eret_req;
    logic        mtc0_valid;
    logic [4:0]  mtc0_addr;
    logic [31:0] mtc0_data;
    logic [31:0] SR_value;
    logic [31:0] Cause_value;
    logic [31:0] EPC_value;
    logic [31:0] SR_input;
    logic        SR_enable;
    logic [31:0] Cause_input;
    logic        Cause_enable;
    logic [31:0] EPC_input;
    logic        EPC_enable;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    exception_controller dut (
        .clk            (clk),
        .reset          (reset),
        .HWInt          (HWInt),
        .victim_pc      (victim_pc),
        .victim_bd      (victim_bd),
        .exc_valid      (exc_valid),
        .exc_code       (exc_code),
        .eret_req       (eret_req),
        .mtc0_valid     (mtc0_valid),
        .mtc0_addr      (mtc0_addr),
        .mtc0_data      (mtc0_data),
        .SR_value       (SR_value),
        .Cause_value    (Cause_value),
        .EPC_value      (EPC_value),
        .SR_input       (SR_input),
        .SR_enable      (SR_enable),
        .Cause_input    (Cause_input),
        .Cause_enable   (Cause_enable),
        .EPC_input      (EPC_input),
        .EPC_enable     (EPC_enable),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .busy           (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_reqs();
        exc_valid  = 1'b0;
        eret_req   = 1'b0;
        mtc0_valid = 1'b0;
    endtask

    task automatic check_no_writes(input string tag);
        check({tag, "_sr_en"}, 32'(SR_enable), 32'd0);
        check({tag, "_cause_en"}, 32'(Cause_enable), 32'd0);
        check({tag, "_epc_en"}, 32'(EPC_enable), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; HWInt = 6'h3F; victim_pc = 32'h3000; victim_bd = 1'b0;
        exc_valid = 1'b1; exc_code = 5'd4; eret_req = 1'b0; mtc0_valid = 1'b0;
        mtc0_addr = 5'd0; mtc0_data = 32'd0;
        SR_value = 32'h0000_FC01; Cause_value = 32'd0; EPC_value = 32'd0;

        // Reset: requests present but everything gated.
        repeat (2) @(negedge clk);
        check("rst_rv", 32'(redirect_valid), 32'd0);
        check("rst_rpc", redirect_pc, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check_no_writes("rst");

        idle_reqs(); HWInt = 6'd0; reset = 1'b1;
        @(negedge clk);
        check("idle_rv", 32'(redirect_valid), 32'd0);
        check("idle_cause_en", 32'(Cause_enable), 32'd1);
        check("idle_sr_en", 32'(SR_enable), 32'd0);

        // Interrupt take.
        HWInt = 6'b000100; victim_pc = 32'h3010; victim_bd = 1'b0; Cause_value = 32'd0;
        #1;
        check("int_sr_en", 32'(SR_enable), 32'd1);
        check("int_sr_in", SR_input, 32'h0000_FC03);
        check("int_epc_en", 32'(EPC_enable), 32'd1);
        check("int_epc_in", EPC_input, 32'h0000_3010);
        check("int_cause_in", Cause_input, 32'h0000_1000);
        @(negedge clk);
        check("int_rv", 32'(redirect_valid), 32'd1);
        check("int_rpc", redirect_pc, 32'h0000_4180);
        check("int_busy", 32'(busy), 32'd1);
        check_no_writes("trap");
        HWInt = 6'd0; SR_value = 32'h0000_FC03;
        @(negedge clk);
        check("int_rv_drop", 32'(redirect_valid), 32'd0);
        check("int_busy_drop", 32'(busy), 32'd0);

        // Exception in a delay slot; held Cause bits are replaced by the take fields.
        SR_value = 32'h0000_FC01; Cause_value = 32'h0000_FC7C;
        exc_valid = 1'b1; exc_code = 5'd12; victim_pc = 32'h3024; victim_bd = 1'b1;
        #1;
        check("exc_epc_in", EPC_input, 32'h0000_3020);
        check("exc_cause_in", Cause_input, 32'h8000_0030);
        check("exc_sr_in", SR_input, 32'h0000_FC03);
        @(negedge clk);
        check("exc_rpc", redirect_pc, 32'h0000_4180);
        check("exc_rv", 32'(redirect_valid), 32'd1);
        idle_reqs(); victim_bd = 1'b0; SR_value = 32'h0000_FC03; Cause_value = 32'd0;
        @(negedge clk);

        // Interrupt beats exception and mtc0 in the same cycle.
        SR_value = 32'h0000_FC01; HWInt = 6'b000001; victim_pc = 32'h3050;
        exc_valid = 1'b1; exc_code = 5'd10;
        mtc0_valid = 1'b1; mtc0_addr = 5'd12; mtc0_data = 32'hDEAD_BEEF;
        #1;
        check("sim_sr_in", SR_input, 32'h0000_FC03);
        check("sim_cause_in", Cause_input, 32'h0000_0400);
        check("sim_epc_in", EPC_input, 32'h0000_3050);
        @(negedge clk);
        check("sim_rpc", redirect_pc, 32'h0000_4180);
        idle_reqs(); HWInt = 6'd0; SR_value = 32'h0000_FC03;
        @(negedge clk);

        // eret back to EPC, then interrupt pending in the following RUN cycles.
        EPC_value = 32'h3040; eret_req = 1'b1; victim_pc = 32'h3060;
        #1;
        check("eret_sr_en", 32'(SR_enable), 32'd1);
        check("eret_sr_in", SR_input, 32'h0000_FC01);
        check("eret_epc_en", 32'(EPC_enable), 32'd0);
        @(negedge clk);
        check("eret_rv", 32'(redirect_valid), 32'd1);
        check("eret_rpc", redirect_pc, 32'h0000_3040);
        check("eret_busy", 32'(busy), 32'd1);
        idle_reqs(); SR_value = 32'h0000_FC01; HWInt = 6'b000100;
        @(negedge clk);
`ifdef EXC_HOLDOFF_EN
        for (int i = 0; i < 3; i++) begin
            check("hold_no_take", 32'(SR_enable), 32'd0);
            @(negedge clk);
        end
`endif
        check("hold_take", 32'(SR_enable), 32'd1);
        check("hold_take_epc", EPC_input, 32'h0000_3060);
        @(negedge clk);
        check("hold_take_rpc", redirect_pc, 32'h0000_4180);
        HWInt = 6'd0; SR_value = 32'h0000_FC03;
        @(negedge clk);

        // Masked by EXL; mtc0 routing.
        SR_value = 32'h0000_FC02; HWInt = 6'h3F; Cause_value = 32'd0;
        #1;
        check("mask_sr_en", 32'(SR_enable), 32'd0);
        check("mask_epc_en", 32'(EPC_enable), 32'd0);
        check("mask_cause_in", Cause_input, 32'h0000_FC00);
        mtc0_valid = 1'b1; mtc0_addr = 5'd13; mtc0_data = 32'hFFFF_FFFF;
        #1;
        check("mtc0_13_cause", Cause_input, 32'h0000_FC00);
        check("mtc0_13_sr_en", 32'(SR_enable), 32'd0);
        mtc0_addr = 5'd14; mtc0_data = 32'h1234;
        #1;
        check("mtc0_14_en", 32'(EPC_enable), 32'd1);
        check("mtc0_14_in", EPC_input, 32'h0000_1234);
        mtc0_addr = 5'd12; mtc0_data = 32'h0000_0401;
        #1;
        check("mtc0_12_in", SR_input, 32'h0000_0401);
        @(negedge clk);
        check("mtc0_no_rv", 32'(redirect_valid), 32'd0);
        idle_reqs(); HWInt = 6'd0; SR_value = 32'h0000_FC03;

        // Reset during TRAP cancels the redirect.
        exc_valid = 1'b1; exc_code = 5'd4; victim_pc = 32'h3000;
        @(negedge clk);
        check("rt_busy", 32'(busy), 32'd1);
        idle_reqs(); reset = 1'b0;
        @(negedge clk);
        check("rt_rv", 32'(redirect_valid), 32'd0);
        check("rt_busy_drop", 32'(busy), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // PC wrap for a delay-slot victim at address 0.
        Cause_value = 32'd0; exc_valid = 1'b1; exc_code = 5'd4;
        victim_pc = 32'd0; victim_bd = 1'b1;
        #1;
        check("wrap_epc_in", EPC_input, 32'hFFFF_FFFC);
        check("wrap_cause_in", Cause_input, 32'h8000_0010);
        @(negedge clk);
        idle_reqs();
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
